iir_delay_ram: RTL and testbench

IIR_DELAY_RAM -- requirements
Module: iir_delay_ram

---
 rtl/iir_delay_ram.sv | 169 ++++++++++++++++
 tb/tb_iir_delay_ram.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/iir_delay_ram.sv
`default_nettype none
// ============================================================================
//  Module   : iir_delay_ram
//  Brief    : Multi-channel circular delay-line RAM for IIR filter state.
//             Each channel owns DEPTH words addressed relative to a
//             per-channel head pointer. A clear FSM zeroes the whole array
//             one word per cycle after reset or on request.
//  Options  : IIR_DELAY_RAM_WR_FWD_EN - when defined, a read and a write to
//             the same physical word in one cycle return the new write data.
//             When undefined, the read returns the previously stored word.
//  Revision : 1.0 - initial release
// ============================================================================
module iir_delay_ram #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 6,
    parameter int CHANNELS   = 2,
    // Derived widths; not intended to be overridden.
    parameter int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  we,
    input  logic [CW-1:0]         wch,
    input  logic [ADDR_WIDTH-1:0] woff,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  re,
    input  logic [CW-1:0]         rch,
    input  logic [ADDR_WIDTH-1:0] roff,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  adv,
    input  logic [CW-1:0]         ach
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int TOTAL  = CHANNELS * DEPTH;
    localparam int AW_TOT = CW + ADDR_WIDTH;

    localparam logic [CW:0]       c_NCH  = (CW + 1)'(CHANNELS);
    localparam logic [AW_TOT-1:0] c_LAST = AW_TOT'(TOTAL - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    logic [AW_TOT-1:0]       r_cnt;
    logic                    r_busy;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_dout_valid;
    logic [ADDR_WIDTH-1:0]   r_head [CHANNELS];
    logic [DATA_WIDTH-1:0]   r_mem  [TOTAL];

    logic                    w_wch_ok;
    logic                    w_rch_ok;
    logic                    w_ach_ok;
    logic [ADDR_WIDTH-1:0]   w_whead;
    logic [ADDR_WIDTH-1:0]   w_rhead;
    logic [AW_TOT-1:0]       w_waddr;
    logic [AW_TOT-1:0]       w_raddr;
    logic                    w_wr_en;
    logic                    w_idle;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    // Channel range checks; out-of-range channels never touch state.
    assign w_wch_ok = ({1'b0, wch} < c_NCH);
    assign w_rch_ok = ({1'b0, rch} < c_NCH);
    assign w_ach_ok = ({1'b0, ach} < c_NCH);

    // Heads are sampled before any advance in this cycle takes effect.
    assign w_whead = w_wch_ok ? r_head[wch] : '0;
    assign w_rhead = w_rch_ok ? r_head[rch] : '0;

    // Channel base is ch*DEPTH, so the channel forms the upper address bits;
    // the offset sum wraps naturally at DEPTH in ADDR_WIDTH bits.
    assign w_waddr = {wch, ADDR_WIDTH'(w_whead + woff)};
    assign w_raddr = {rch, ADDR_WIDTH'(w_rhead + roff)};

    assign w_idle  = (r_state == S_IDLE);
    assign w_wr_en = w_idle && we && w_wch_ok;

    // Read data source, with optional read-during-write forwarding.
    always_comb begin
        w_rd_data = '0;
        if (w_rch_ok) begin
`ifdef IIR_DELAY_RAM_WR_FWD_EN
            if (w_wr_en && (w_waddr == w_raddr)) begin
                w_rd_data = din;
            end else begin
                w_rd_data = r_mem[w_raddr];
            end
`else
            w_rd_data = r_mem[w_raddr];
`endif
        end
    end

    // Storage array: clear sweep has priority over user writes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_en) begin
                r_mem[w_waddr] <= din;
            end
        end
    end

    // Control FSM, head pointers and registered read port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_head[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dout_valid <= re;
                    if (re) begin
                        r_dout <= w_rd_data;
                    end
                    if (adv && w_ach_ok) begin
                        r_head[ach] <= r_head[ach] + 1'b1;
                    end
                    if (clr) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        for (int i = 0; i < CHANNELS; i++) begin
                            r_head[i] <= '0;
                        end
                    end
                end
                S_CLEAR: begin
                    r_dout_valid <= 1'b0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        r_head[i] <= '0;
                    end
                    if (r_cnt == c_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_iir_delay_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iir_delay_ram
//  Brief    : Scoreboard bench for iir_delay_ram (ADDR_WIDTH=3, DATA_WIDTH=6,
//             CHANNELS=2) with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iir_delay_ram;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       clr = 1'b0;
    logic       busy;
    logic       we = 1'b0;
    logic [0:0] wch = '0;
    logic [2:0] woff = '0;
    logic [5:0] din = '0;
    logic       re = 1'b0;
    logic [0:0] rch = '0;
    logic [2:0] roff = '0;
    logic [5:0] dout;
    logic       dout_valid;
    logic       adv = 1'b0;
    logic [0:0] ach = '0;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q [$];

    iir_delay_ram #(.ADDR_WIDTH(3), .DATA_WIDTH(6), .CHANNELS(2)) dut (
        .CLK(CLK), .RST(RST), .clr(clr), .busy(busy),
        .we(we), .wch(wch), .woff(woff), .din(din),
        .re(re), .rch(rch), .roff(roff),
        .dout(dout), .dout_valid(dout_valid),
        .adv(adv), .ach(ach)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid read result is matched against the oldest expectation.
    always @(negedge CLK) begin
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_read: got 0x%0h expected no output", dout);
            end else begin
                chk("read_data", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    // One bus cycle: drive inputs, record expected read data, release after the edge.
    task automatic op(input logic i_we, input logic i_wch, input logic [2:0] i_woff,
                      input logic [5:0] i_din, input logic i_re, input logic i_rch,
                      input logic [2:0] i_roff, input logic [5:0] i_exp,
                      input logic i_adv, input logic i_ach, input logic i_clr);
        we = i_we; wch = i_wch; woff = i_woff; din = i_din;
        re = i_re; rch = i_rch; roff = i_roff;
        adv = i_adv; ach = i_ach; clr = i_clr;
        if (i_re) exp_q.push_back(i_exp);
        @(posedge CLK);
        #1;
        we = 1'b0; re = 1'b0; adv = 1'b0; clr = 1'b0;
    endtask

    task automatic wr(input logic ch, input logic [2:0] off, input logic [5:0] d);
        op(1'b1, ch, off, d, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic ch, input logic [2:0] off, input logic [5:0] e);
        op(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, ch, off, e, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic advance(input logic ch);
        op(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b1, ch, 1'b0);
    endtask

    // Count negedges with busy high; optionally poke we/re/adv/clr mid-clear.
    task automatic count_busy(input string name, input int exp, input bit poke);
        int n;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (!busy) break;
            n++;
            if (poke && n == 3) begin
                we = 1'b1; wch = 1'b0; woff = 3'd0; din = 6'h3F;
                re = 1'b1; rch = 1'b0; roff = 3'd0;
                adv = 1'b1; ach = 1'b0; clr = 1'b1;
            end
            if (poke && n == 4) begin
                we = 1'b0; re = 1'b0; adv = 1'b0; clr = 1'b0;
            end
        end
        chk(name, n, exp);
        @(posedge CLK);
        #1;
    endtask

    task automatic read_all_zero();
        for (int c = 0; c < 2; c++)
            for (int o = 0; o < 8; o++)
                rd(c[0], o[2:0], 6'd0);
    endtask

    initial begin
        // Reset state.
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", int'(busy), 1);
        chk("rst_dout", int'(dout), 0);
        chk("rst_valid", int'(dout_valid), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        count_busy("busy_after_reset", 16, 1'b0);

        // All words cleared, heads at zero.
        read_all_zero();

        // Fill ch0 with 0..7; channel isolation.
        for (int o = 0; o < 8; o++) wr(1'b0, o[2:0], o[5:0]);
        rd(1'b0, 3'd3, 6'd3);
        rd(1'b1, 3'd3, 6'd0);
        rd(1'b0, 3'd7, 6'd7);

        // Head advance and wrap.
        advance(1'b0);
        rd(1'b0, 3'd0, 6'd1);
        rd(1'b0, 3'd7, 6'd0);
        for (int k = 0; k < 7; k++) advance(1'b0);
        rd(1'b0, 3'd0, 6'd0);
        rd(1'b0, 3'd5, 6'd5);

        // Write + advance same cycle uses pre-advance head (phys 10).
        op(1'b1, 1'b1, 3'd2, 6'h2A, 1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b1, 1'b0);
        rd(1'b1, 3'd1, 6'h2A);
        rd(1'b1, 3'd2, 6'd0);

        // Read and write of same word in one cycle.
`ifdef IIR_DELAY_RAM_WR_FWD_EN
        op(1'b1, 1'b0, 3'd5, 6'h15, 1'b1, 1'b0, 3'd5, 6'h15, 1'b0, 1'b0, 1'b0);
`else
        op(1'b1, 1'b0, 3'd5, 6'h15, 1'b1, 1'b0, 3'd5, 6'd5, 1'b0, 1'b0, 1'b0);
`endif
        rd(1'b0, 3'd5, 6'h15);

        // Read and advance in one cycle: read sees old head; new head next cycle.
        op(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, 1'b0, 3'd1, 6'd1, 1'b1, 1'b0, 1'b0);
        rd(1'b0, 3'd1, 6'd2);

        // Clear mid-traffic, then reset at clear cycle 4.
        rd(1'b0, 3'd2, 6'd3);
        op(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        chk("busy_after_clr", int'(busy), 1);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        count_busy("busy_after_midclear_rst", 16, 1'b1);
        read_all_zero();

        // Heads back at zero: write ch1 off0 must land at phys 8, not 9.
        wr(1'b1, 3'd0, 6'h11);
        rd(1'b1, 3'd0, 6'h11);
        rd(1'b1, 3'd1, 6'd0);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
